// File: rtl/vending_ctrl_pkg.sv
// Shared types and defaults for the multi-product vending controller.
// Holds the state encoding, coin codes and the default price/coin tables.
package vending_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CREDIT = 2'd1,
      ST_VEND   = 2'd2,
      ST_CHANGE = 2'd3
   } vend_state_e;

   localparam logic [1:0] COIN_10  = 2'd0;
   localparam logic [1:0] COIN_20  = 2'd1;
   localparam logic [1:0] COIN_50  = 2'd2;
   localparam logic [1:0] COIN_100 = 2'd3;

   localparam int DEF_CREDIT_W   = 8;
   localparam int DEF_NPROD      = 4;
   localparam int DEF_MAX_CREDIT = 200;

   // Product i / coin code i occupy bits [i*8 +: 8]; entry 0 is the rightmost.
   localparam logic [DEF_NPROD*DEF_CREDIT_W-1:0] DEF_PRICE_VEC    = {8'd100, 8'd60, 8'd30, 8'd40};
   localparam logic [4*DEF_CREDIT_W-1:0]         DEF_COIN_VAL_VEC = {8'd100, 8'd50, 8'd20, 8'd10};

endpackage

// File: rtl/vending_ctrl_if.sv
// Coin acceptor / selector / dispenser bundle for vending_ctrl.
// master = the machine front-end and dispensers, slave = the controller.
interface vending_ctrl_if #(
   parameter int CREDIT_W = 8,
   parameter int NPROD    = 4
);
   localparam int SEL_W = $clog2(NPROD);

   logic                coin_valid;
   logic [1:0]          coin;
   logic                sel_valid;
   logic [SEL_W-1:0]    sel;
   logic                cancel;
   logic                ack;

   logic                pdt_valid;
   logic [SEL_W-1:0]    pdt_id;
   logic                chg_valid;
   logic [CREDIT_W-1:0] chg_amt;
   logic [CREDIT_W-1:0] credit;
   logic                coin_reject;
   logic                sel_reject;

   modport master (
      output coin_valid, coin, sel_valid, sel, cancel, ack,
      input  pdt_valid, pdt_id, chg_valid, chg_amt, credit, coin_reject, sel_reject
   );

   modport slave (
      input  coin_valid, coin, sel_valid, sel, cancel, ack,
      output pdt_valid, pdt_id, chg_valid, chg_amt, credit, coin_reject, sel_reject
   );

endinterface

// File: rtl/vending_ctrl_credit_acc.sv
// Credit accumulator: coin value lookup, overflow check against MAX_CREDIT,
// and price compare/subtract for the selected product.
module vend_credit_acc
   import vending_ctrl_pkg::*;
#(
   parameter int                          CREDIT_W     = DEF_CREDIT_W,
   parameter int                          NPROD        = DEF_NPROD,
   parameter logic [NPROD*CREDIT_W-1:0]   PRICE_VEC    = DEF_PRICE_VEC,
   parameter logic [4*CREDIT_W-1:0]       COIN_VAL_VEC = DEF_COIN_VAL_VEC,
   parameter int                          MAX_CREDIT   = DEF_MAX_CREDIT,
   localparam int                         SEL_W        = $clog2(NPROD)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          coin_i,
   input  logic [SEL_W-1:0]    sel_i,
   input  logic                add_i,
   input  logic                clr_i,
   output logic [CREDIT_W-1:0] credit_o,
   output logic                coin_ok_o,
   output logic                price_ok_o,
   output logic [CREDIT_W-1:0] diff_o
);

   localparam logic [CREDIT_W:0] MAX_EXT = (CREDIT_W+1)'(MAX_CREDIT);

   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [CREDIT_W-1:0] coin_val;
   logic [CREDIT_W-1:0] price;
   logic [CREDIT_W:0]   sum;
   logic                sel_in_range;

   always_comb begin
      coin_val = '0;
      for (int i = 0; i < 4; i++) begin
         if (coin_i == 2'(i)) coin_val = COIN_VAL_VEC[i*CREDIT_W +: CREDIT_W];
      end
   end

   // An out-of-range index matches no entry, so it can never satisfy the price check.
   always_comb begin
      price        = '0;
      sel_in_range = 1'b0;
      for (int i = 0; i < NPROD; i++) begin
         if (sel_i == SEL_W'(i)) begin
            price        = PRICE_VEC[i*CREDIT_W +: CREDIT_W];
            sel_in_range = 1'b1;
         end
      end
   end

   assign sum        = {1'b0, credit_q} + {1'b0, coin_val};
   assign coin_ok_o  = (sum <= MAX_EXT);
   assign price_ok_o = sel_in_range && (credit_q >= price);
   assign diff_o     = credit_q - price;
   assign credit_o   = credit_q;

   always_comb begin
      credit_d = credit_q;
      if (clr_i)      credit_d = '0;
      else if (add_i) credit_d = sum[CREDIT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!reset) credit_q <= '0;
      else        credit_q <= credit_d;
   end

endmodule

// File: rtl/vending_ctrl.sv
// Multi-product vending controller: sequencing FSM, dispenser handshakes
// and reject pulses around the vend_credit_acc credit datapath.
//
//   state     | meaning
//   ----------+--------------------------------------------
//   ST_IDLE   | no credit; coins accepted, selections refused
//   ST_CREDIT | credit > 0; coins, selection and cancel accepted
//   ST_VEND   | pdt_valid held until ack
//   ST_CHANGE | chg_valid/chg_amt held until ack
module vending_ctrl
   import vending_ctrl_pkg::*;
#(
   parameter int                          CREDIT_W     = DEF_CREDIT_W,
   parameter int                          NPROD        = DEF_NPROD,
   parameter logic [NPROD*CREDIT_W-1:0]   PRICE_VEC    = DEF_PRICE_VEC,
   parameter logic [4*CREDIT_W-1:0]       COIN_VAL_VEC = DEF_COIN_VAL_VEC,
   parameter int                          MAX_CREDIT   = DEF_MAX_CREDIT,
   localparam int                         SEL_W        = $clog2(NPROD)
) (
   input  logic           clk,
   input  logic           reset,
   vending_ctrl_if.slave  bus
);

   vend_state_e         state_q, state_d;
   logic [CREDIT_W-1:0] rem_q, rem_d;
   logic                pdt_valid_q, pdt_valid_d;
   logic [SEL_W-1:0]    pdt_id_q, pdt_id_d;
   logic                chg_valid_q, chg_valid_d;
   logic [CREDIT_W-1:0] chg_amt_q, chg_amt_d;
   logic                coin_rej_q, coin_rej_d;
   logic                sel_rej_q, sel_rej_d;

   logic                acc_add, acc_clr;
   logic                coin_ok, price_ok;
   logic [CREDIT_W-1:0] credit, diff;

   vend_credit_acc #(
      .CREDIT_W     (CREDIT_W),
      .NPROD        (NPROD),
      .PRICE_VEC    (PRICE_VEC),
      .COIN_VAL_VEC (COIN_VAL_VEC),
      .MAX_CREDIT   (MAX_CREDIT)
   ) u_acc (
      .clk        (clk),
      .reset      (reset),
      .coin_i     (bus.coin),
      .sel_i      (bus.sel),
      .add_i      (acc_add),
      .clr_i      (acc_clr),
      .credit_o   (credit),
      .coin_ok_o  (coin_ok),
      .price_ok_o (price_ok),
      .diff_o     (diff)
   );

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      pdt_valid_d = pdt_valid_q;
      pdt_id_d    = pdt_id_q;
      chg_valid_d = chg_valid_q;
      chg_amt_d   = chg_amt_q;
      coin_rej_d  = 1'b0;
      sel_rej_d   = 1'b0;
      acc_add     = 1'b0;
      acc_clr     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            sel_rej_d = bus.sel_valid;
            if (bus.coin_valid) begin
               if (coin_ok) begin
                  acc_add = 1'b1;
                  state_d = ST_CREDIT;
               end else begin
                  coin_rej_d = 1'b1;
               end
            end
         end

         ST_CREDIT: begin
            // cancel > sel_valid > coin_valid; a coin that loses is handed back
            if (bus.cancel) begin
               rem_d       = credit;
               chg_valid_d = 1'b1;
               chg_amt_d   = credit;
               acc_clr     = 1'b1;
               coin_rej_d  = bus.coin_valid;
               state_d     = ST_CHANGE;
            end else if (bus.sel_valid) begin
               coin_rej_d = bus.coin_valid;
               if (price_ok) begin
                  rem_d       = diff;
                  pdt_valid_d = 1'b1;
                  pdt_id_d    = bus.sel;
                  acc_clr     = 1'b1;
                  state_d     = ST_VEND;
               end else begin
                  sel_rej_d = 1'b1;
               end
            end else if (bus.coin_valid) begin
               if (coin_ok) acc_add    = 1'b1;
               else         coin_rej_d = 1'b1;
            end
         end

         ST_VEND: begin
            coin_rej_d = bus.coin_valid;
            sel_rej_d  = bus.sel_valid;
            if (bus.ack) begin
               pdt_valid_d = 1'b0;
               if (rem_q != '0) begin
                  chg_valid_d = 1'b1;
                  chg_amt_d   = rem_q;
                  state_d     = ST_CHANGE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         ST_CHANGE: begin
            coin_rej_d = bus.coin_valid;
            sel_rej_d  = bus.sel_valid;
            if (bus.ack) begin
               chg_valid_d = 1'b0;
               chg_amt_d   = '0;
               rem_d       = '0;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            rem_d       = '0;
            pdt_valid_d = 1'b0;
            pdt_id_d    = '0;
            chg_valid_d = 1'b0;
            chg_amt_d   = '0;
            acc_clr     = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         rem_q       <= '0;
         pdt_valid_q <= 1'b0;
         pdt_id_q    <= '0;
         chg_valid_q <= 1'b0;
         chg_amt_q   <= '0;
         coin_rej_q  <= 1'b0;
         sel_rej_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         pdt_valid_q <= pdt_valid_d;
         pdt_id_q    <= pdt_id_d;
         chg_valid_q <= chg_valid_d;
         chg_amt_q   <= chg_amt_d;
         coin_rej_q  <= coin_rej_d;
         sel_rej_q   <= sel_rej_d;
      end
   end

   assign bus.pdt_valid   = pdt_valid_q;
   assign bus.pdt_id      = pdt_id_q;
   assign bus.chg_valid   = chg_valid_q;
   assign bus.chg_amt     = chg_amt_q;
   assign bus.credit      = credit;
   assign bus.coin_reject = coin_rej_q;
   assign bus.sel_reject  = sel_rej_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Directed bench for vending_ctrl with hand-computed expectations.
// Default tables: prices p0=40 p1=30 p2=60 p3=100, coins 10/20/50/100, max 200.
module tb_vending_ctrl;
   import vending_ctrl_pkg::*;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   vending_ctrl_if #(.CREDIT_W(8), .NPROD(4)) vif ();

   vending_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (vif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_strobes();
      vif.coin_valid = 1'b0;
      vif.sel_valid  = 1'b0;
      vif.cancel     = 1'b0;
      vif.ack        = 1'b0;
   endtask

   task automatic put_coin(input logic [1:0] c);
      vif.coin_valid = 1'b1;
      vif.coin       = c;
      tick();
      clear_strobes();
   endtask

   task automatic select(input logic [1:0] s);
      vif.sel_valid = 1'b1;
      vif.sel       = s;
      tick();
      clear_strobes();
   endtask

   task automatic do_ack();
      vif.ack = 1'b1;
      tick();
      clear_strobes();
   endtask

   task automatic do_cancel();
      vif.cancel = 1'b1;
      tick();
      clear_strobes();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      clear_strobes();
      vif.coin = 2'd0;
      vif.sel  = 2'd0;
      reset    = 1'b0;

      // 1: reset, exact-price vend of product 0
      tick();
      tick();
      reset = 1'b1;
      chk("rst_credit",    32'(vif.credit), 0);
      chk("rst_pdt_valid", 32'(vif.pdt_valid), 0);
      chk("rst_chg_valid", 32'(vif.chg_valid), 0);
      chk("rst_coin_rej",  32'(vif.coin_reject), 0);
      chk("rst_sel_rej",   32'(vif.sel_reject), 0);
      select(2'd0);
      chk("idle_sel_rej",  32'(vif.sel_reject), 1);
      chk("idle_sel_nopdt",32'(vif.pdt_valid), 0);
      put_coin(COIN_10);
      chk("t1_credit10", 32'(vif.credit), 10);
      chk("t1_selrej_pulse", 32'(vif.sel_reject), 0);
      put_coin(COIN_10);
      chk("t1_credit20", 32'(vif.credit), 20);
      put_coin(COIN_20);
      chk("t1_credit40", 32'(vif.credit), 40);
      select(2'd0);
      chk("t1_pdt_valid", 32'(vif.pdt_valid), 1);
      chk("t1_pdt_id",    32'(vif.pdt_id), 0);
      chk("t1_credit0",   32'(vif.credit), 0);
      do_ack();
      chk("t1_pdt_done",  32'(vif.pdt_valid), 0);
      chk("t1_no_chg",    32'(vif.chg_valid), 0);
      tick();
      chk("t1_no_chg2",   32'(vif.chg_valid), 0);

      // 2: vend with change, outputs stable while ack is low
      put_coin(COIN_50);
      chk("t2_credit50", 32'(vif.credit), 50);
      select(2'd1);
      chk("t2_pdt_valid", 32'(vif.pdt_valid), 1);
      chk("t2_pdt_id",    32'(vif.pdt_id), 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t2_hold_valid", 32'(vif.pdt_valid), 1);
         chk("t2_hold_id",    32'(vif.pdt_id), 1);
         chk("t2_hold_nochg", 32'(vif.chg_valid), 0);
      end
      put_coin(COIN_10);
      chk("t2_vend_coinrej", 32'(vif.coin_reject), 1);
      chk("t2_vend_credit",  32'(vif.credit), 0);
      do_ack();
      chk("t2_pdt_done",  32'(vif.pdt_valid), 0);
      chk("t2_chg_valid", 32'(vif.chg_valid), 1);
      chk("t2_chg_amt",   32'(vif.chg_amt), 20);
      tick();
      chk("t2_chg_hold",  32'(vif.chg_valid), 1);
      chk("t2_chg_amt2",  32'(vif.chg_amt), 20);
      do_ack();
      chk("t2_chg_done",  32'(vif.chg_valid), 0);

      // 3: insufficient credit, then cancel refunds
      put_coin(COIN_20);
      chk("t3_credit20", 32'(vif.credit), 20);
      select(2'd2);
      chk("t3_sel_rej",   32'(vif.sel_reject), 1);
      chk("t3_credit",    32'(vif.credit), 20);
      chk("t3_no_pdt",    32'(vif.pdt_valid), 0);
      tick();
      chk("t3_rej_pulse", 32'(vif.sel_reject), 0);
      do_cancel();
      chk("t3_chg_valid", 32'(vif.chg_valid), 1);
      chk("t3_chg_amt",   32'(vif.chg_amt), 20);
      chk("t3_credit0",   32'(vif.credit), 0);
      do_ack();
      chk("t3_chg_done",  32'(vif.chg_valid), 0);

      // 4: fill to MAX_CREDIT, overflow coin refused, vend product 3
      put_coin(COIN_100);
      put_coin(COIN_100);
      chk("t4_credit200", 32'(vif.credit), 200);
      put_coin(COIN_10);
      chk("t4_coin_rej",  32'(vif.coin_reject), 1);
      chk("t4_credit",    32'(vif.credit), 200);
      tick();
      chk("t4_rej_pulse", 32'(vif.coin_reject), 0);
      select(2'd3);
      chk("t4_pdt_valid", 32'(vif.pdt_valid), 1);
      chk("t4_pdt_id",    32'(vif.pdt_id), 3);
      do_ack();
      chk("t4_chg_valid", 32'(vif.chg_valid), 1);
      chk("t4_chg_amt",   32'(vif.chg_amt), 100);
      do_ack();
      chk("t4_chg_done",  32'(vif.chg_valid), 0);

      // 5: cancel wins over select and coin in the same cycle
      put_coin(COIN_50);
      vif.cancel     = 1'b1;
      vif.sel_valid  = 1'b1;
      vif.sel        = 2'd0;
      vif.coin_valid = 1'b1;
      vif.coin       = COIN_10;
      tick();
      clear_strobes();
      chk("t5_chg_valid", 32'(vif.chg_valid), 1);
      chk("t5_chg_amt",   32'(vif.chg_amt), 50);
      chk("t5_coin_rej",  32'(vif.coin_reject), 1);
      chk("t5_no_pdt",    32'(vif.pdt_valid), 0);
      chk("t5_no_selrej", 32'(vif.sel_reject), 0);
      chk("t5_credit0",   32'(vif.credit), 0);
      do_ack();

      // 6: reset is synchronous and discards a pending vend
      put_coin(COIN_50);
      select(2'd0);
      chk("t6_pdt_valid", 32'(vif.pdt_valid), 1);
      reset = 1'b0;
      #3;
      reset = 1'b1;
      tick();
      chk("t6_glitch_pdt", 32'(vif.pdt_valid), 1);
      chk("t6_glitch_id",  32'(vif.pdt_id), 0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("t6_rst_pdt",    32'(vif.pdt_valid), 0);
      chk("t6_rst_chg",    32'(vif.chg_valid), 0);
      chk("t6_rst_credit", 32'(vif.credit), 0);
      do_ack();
      chk("t6_ack_ignored", 32'(vif.chg_valid), 0);
      chk("t6_ack_nopdt",   32'(vif.pdt_valid), 0);
      put_coin(COIN_20);
      chk("t6_credit20", 32'(vif.credit), 20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vending_ctrl.md
Name: vending_ctrl

Overview:
Parametrised multi-product vending controller and successor to the fixed single-price vending FSM. It accumulates coin credit with overflow rejection and supports NPROD products, each with its own price. It also supports cancel/refund, an exact change amount output, and ready/ack handshakes for the product and change dispensers. It sits between the coin acceptor and the dispenser/change-hopper drivers.

Parameters:
CREDIT_W, 8, width of credit, price and change values (units of 1 rupee)
NPROD, 4, number of selectable products (>=2)
PRICE_VEC, {8'd100,8'd60,8'd30,8'd40}, packed NPROD*CREDIT_W prices; product i price = PRICE_VEC[i*CREDIT_W +: CREDIT_W]
COIN_VAL_VEC, {8'd100,8'd50,8'd20,8'd10}, packed 4*CREDIT_W values for coin codes 0..3
MAX_CREDIT, 200, highest credit accepted; must be < 2**CREDIT_W

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
coin_valid  in  1  one-cycle coin-inserted strobe
coin  in  2  coin code, qualified by coin_valid
sel_valid  in  1  one-cycle product-select strobe
sel  in  $clog2(NPROD)  product index
cancel  in  1  one-cycle refund request
ack  in  1  dispenser accepted current pdt/chg item
pdt_valid  out  1  product dispense request, held until ack
pdt_id  out  $clog2(NPROD)  product being dispensed
chg_valid  out  1  change dispense request, held until ack
chg_amt  out  CREDIT_W  change amount
credit  out  CREDIT_W  current accumulated credit
coin_reject  out  1  one-cycle pulse: coin refused, must be returned
sel_reject  out  1  one-cycle pulse: selection refused (insufficient credit or sel>=NPROD)

Behaviour:
- Reset: on a rising edge with reset==0, state=IDLE and all outputs, credit and the remainder register go to 0. Reset is synchronous, so reset==0 between edges has no effect. Reset mid-vend discards credit and the pending item.
- All outputs are registered. Every response appears on the edge after its cause.
- States:
  - IDLE: credit==0.
  - CREDIT: credit>0, accepting coins and selection.
  - VEND: pdt_valid=1.
  - CHANGE: chg_valid=1.
- Coin handling in IDLE or CREDIT:
  - If credit+val(coin) <= MAX_CREDIT, credit += val and the FSM moves to CREDIT.
  - Otherwise coin_reject pulses and credit is unchanged.
  - The sum is computed at CREDIT_W+1 bits so it cannot wrap.
- Selection in CREDIT:
  - If sel<NPROD and credit >= price(sel): latch pdt_id=sel, remainder=credit-price, credit=0, go to VEND.
  - Otherwise sel_reject pulses and the state is unchanged.
  - sel_valid in IDLE gives sel_reject.
- Cancel:
  - In CREDIT: remainder=credit, credit=0, go to CHANGE.
  - Ignored in IDLE, VEND and CHANGE.
- Same-cycle priority in CREDIT is cancel > sel_valid > coin_valid. A coin that loses priority gets a coin_reject pulse. A selection that loses to cancel is dropped silently.
- VEND:
  - pdt_valid and pdt_id stay stable until ack.
  - On ack: go to CHANGE if remainder!=0, else IDLE.
  - A price exactly equal to credit never produces chg_valid.
- CHANGE:
  - chg_valid=1 and chg_amt=remainder, both stable until ack.
  - On ack: clear remainder, go to IDLE.
- Coins arriving in VEND or CHANGE get a coin_reject pulse. sel_valid in VEND or CHANGE gives sel_reject.
- ack outside VEND/CHANGE is ignored.
- Unreachable state encodings recover to IDLE with outputs cleared.

Decomposition:
- Shared header vending_defs.vh holds:
  - state encodings IDLE/CREDIT/VEND/CHANGE;
  - coin code constants COIN_10=0, COIN_20=1, COIN_50=2, COIN_100=3;
  - default price and coin vectors.
- One sub-module, vend_credit_acc, holds the credit register, coin value lookup, the overflow compare against MAX_CREDIT, and the price compare/subtract. It takes load/clear controls from the FSM.
- vending_ctrl holds the FSM, the handshake registers and the reject pulses.

Test Plan:
1. Reset low for 2 edges, then coins 0,0,1 (credit 10,20,40), then sel=0 -> next edge pdt_valid=1, pdt_id=0, credit=0. Ack -> IDLE; chg_valid never asserts.
2. Coin 2 (credit 50), sel=1 (price 30) -> pdt_valid. Hold ack low 5 cycles: outputs stable. Ack -> chg_valid=1, chg_amt=20. Ack -> IDLE.
3. Coin 1 (credit 20), sel=2 (price 60) -> sel_reject for 1 cycle, credit stays 20. Then cancel -> chg_valid, chg_amt=20.
4. Coins 3,3 (credit 200), then coin 0 -> coin_reject pulse, credit stays 200. Then sel=3 -> pdt_id=3, remainder 100 -> chg_amt=100.
5. At credit 50, assert cancel, sel_valid(sel=0) and coin_valid(coin=0) in the same cycle -> CHANGE with chg_amt=50, coin_reject=1, no pdt_valid, no sel_reject.
6. Drop reset while pdt_valid=1, pulsing it between edges first -> nothing changes until the edge with reset==0. At that edge pdt_valid, chg_valid and credit become 0 and the FSM is in IDLE. A subsequent coin accumulates normally.
